// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and default width for the serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } sa_state_t;

  localparam int SA_N = 8;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full adder
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - serial adder control FSM, carry and bit counter
// Optional carry-in port enabled by SERIAL_ADD_CIN_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int N     = SA_N,
  localparam int CNT_W = $clog2(N)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_a_bit,
  input  logic i_b_bit,
`ifdef SERIAL_ADD_CIN_EN
  input  logic i_cin,
`endif
  output logic o_ld,
  output logic o_shift,
  output logic o_sum_bit,
  output logic o_cout,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  sa_state_t        state;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADD_CIN_EN
  logic             cin_q;
`endif

  full_adder_bit u_fa (
    .a    (i_a_bit),
    .b    (i_b_bit),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bit is Mealy: it follows the operand LSBs within the same ADD cycle.
  assign o_sum_bit = (state == ADD) ? fa_sum : 1'b0;

  // Strobes are registered, so each is set on the edge entering its state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      carry   <= 1'b0;
      cnt     <= '0;
      o_cout  <= 1'b0;
      o_ld    <= 1'b0;
      o_shift <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
`ifdef SERIAL_ADD_CIN_EN
      cin_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state  <= LOAD;
            o_ld   <= 1'b1;
            o_busy <= 1'b1;
`ifdef SERIAL_ADD_CIN_EN
            cin_q  <= i_cin;
`endif
          end
        end
        LOAD: begin
`ifdef SERIAL_ADD_CIN_EN
          carry   <= cin_q;
`else
          carry   <= 1'b0;
`endif
          cnt     <= '0;
          o_cout  <= 1'b0;
          o_ld    <= 1'b0;
          o_shift <= 1'b1;
          state   <= ADD;
        end
        ADD: begin
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            o_cout  <= fa_cout;
            o_shift <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed bench with operand shift-register model around serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int N = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         ld, shift, sum_bit, cout, busy, done;
  logic [N-1:0] a_reg = '0;
  logic [N-1:0] b_reg = '0;
  logic [N-1:0] a_val = '0;
  logic [N-1:0] b_val = '0;
`ifdef SERIAL_ADD_CIN_EN
  logic         cin   = 1'b0;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.N(N)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_a_bit   (a_reg[0]),
    .i_b_bit   (b_reg[0]),
`ifdef SERIAL_ADD_CIN_EN
    .i_cin     (cin),
`endif
    .o_ld      (ld),
    .o_shift   (shift),
    .o_sum_bit (sum_bit),
    .o_cout    (cout),
    .o_busy    (busy),
    .o_done    (done)
  );

  // Operand registers: A takes the sum bit at its MSB, both clear when idle.
  always @(posedge clk) begin
    if (ld) begin
      a_reg <= a_val;
      b_reg <= b_val;
    end else if (shift) begin
      a_reg <= {sum_bit, a_reg[N-1:1]};
      b_reg <= {1'b0, b_reg[N-1:1]};
    end else begin
      a_reg <= '0;
      b_reg <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("ld_shift_excl", 32'(ld & shift), 32'd0);
    check("sum_outside_add", 32'(sum_bit & ~shift), 32'd0);
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
    @(negedge clk);
    a_val = a;
    b_val = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic check_op(input logic [N-1:0] exp, input logic exp_cout);
    @(negedge clk);
    check("load_ld", 32'(ld), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_shift", 32'(shift), 32'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("add_shift", 32'(shift), 32'd1);
      check("add_ld", 32'(ld), 32'd0);
      check("add_busy", 32'(busy), 32'd1);
      check("add_done", 32'(done), 32'd0);
      check("sum_bit", 32'(sum_bit), 32'(exp[i]));
      if (i == 0) check("cout_cleared", 32'(cout), 32'd0);
    end
    @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_shift", 32'(shift), 32'd0);
    check("a_sum", 32'(a_reg), 32'(exp));
    check("cout", 32'(cout), 32'(exp_cout));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ld", 32'(ld), 32'd0);
    check("rst_shift", 32'(shift), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    start_op(8'h35, 8'h4A, 1'b0);
    check_op(8'h7F, 1'b0);

    start_op(8'hFF, 8'h01, 1'b0);
    check_op(8'h00, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("cout_hold", 32'(cout), 32'd1);
      check("idle_done", 32'(done), 32'd0);
    end

    // Start held high: only one extra IDLE cycle before the next LOAD.
    start_op(8'h0F, 8'h0F, 1'b1);
    check_op(8'h1E, 1'b0);
    @(negedge clk);
    check("idle_gap_ld", 32'(ld), 32'd0);
    check("idle_gap_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_op(8'h1E, 1'b0);

    start_op(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_shift", 32'(shift), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ld", 32'(ld), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);

    start_op(8'h80, 8'h80, 1'b0);
    check_op(8'h00, 1'b1);

`ifdef SERIAL_ADD_CIN_EN
    cin = 1'b1;
    start_op(8'hFF, 8'h00, 1'b0);
    check_op(8'h00, 1'b1);
    start_op(8'h05, 8'hFC, 1'b0);
    check_op(8'h02, 1'b1);
    cin = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
